// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame width, default baud divider and receiver state encodings.
// The transmitter takes its default CLOCKS_PER_BAUD from here so both ends of a link agree.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_BITS               = 8;
  localparam int unsigned UART_DEFAULT_CLOCKS_PER_BAUD = 104;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StStop     = 3'd3;
  localparam logic [2:0] StWaitIdle = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid/frame-error strobes, break lockout.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BAUD = UART_DEFAULT_CLOCKS_PER_BAUD,
  parameter int unsigned HALF_BAUD       = CLOCKS_PER_BAUD / 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  output logic                      frame_error_o,
  output logic                      busy_o
);

  localparam int unsigned BaudW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [BaudW-1:0] HalfLoad = BaudW'(HALF_BAUD - 1);
  localparam logic [BaudW-1:0] FullLoad = BaudW'(CLOCKS_PER_BAUD - 1);

  logic rx_s;

  sync_2ff #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk_i(clock),
    .rst_i(reset),
    .d_i  (rx_i),
    .q_o  (rx_s)
  );

  logic [1:0]                settle_q, settle_d;
  logic                      prev_q, prev_d;
  logic [2:0]                state_q, state_d;
  logic [BaudW-1:0]          baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      busy_q, busy_d;
  logic                      fall;
  logic                      tick;

  // The synchronizer shows its reset value for two cycles after reset; prev_q is held low until
  // real samples arrive so a line still low at reset release is not mistaken for a start edge.
  assign fall = prev_q & ~rx_s;
  assign tick = (baud_q == '0);

  always_comb begin
    settle_d = {settle_q[0], 1'b1};
    prev_d   = rx_s & settle_q[1];
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          baud_d  = HalfLoad;
        end
      end
      StStart: begin
        if (!tick) begin
          baud_d = baud_q - BaudW'(1);
        end else if (rx_s) begin
          state_d = StIdle;
        end else begin
          state_d = StData;
          bit_d   = 3'd0;
          baud_d  = FullLoad;
        end
      end
      StData: begin
        if (!tick) begin
          baud_d = baud_q - BaudW'(1);
        end else begin
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          baud_d  = FullLoad;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (!tick) begin
          baud_d = baud_q - BaudW'(1);
        end else begin
          data_d = shift_q;
          // Returning to idle at mid stop bit leaves time to catch an immediate next start edge.
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      settle_q <= 2'b00;
      prev_q   <= 1'b0;
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      settle_q <= settle_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign frame_error_o = ferr_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes at jittered baud rates.
module tb_uart_rx;

  logic       clock;
  logic       reset;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_error_o;
  logic       busy_o;

  uart_rx #(
    .CLOCKS_PER_BAUD(104)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .frame_error_o(frame_error_o),
    .busy_o       (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event log filled on the falling edge, examined by the directed sequence.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         ferr_n;
  int         both_n;
  int         busy_n;

  always @(negedge clock) begin
    if (valid_o) begin
      got_q.push_back(data_o);
      got_cyc.push_back(cyc);
    end
    if (frame_error_o) ferr_n++;
    if (valid_o && frame_error_o) both_n++;
    if (busy_o) busy_n++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_v);
    drive(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(b[i], cpb);
    drive(stop_v, cpb);
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    ferr_n = 0;
    busy_n = 0;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] rb;
  int         fall_cyc;
  int         cpb;
  int         gap;
  int         n_cmp;

  initial begin
    ferr_n = 0;
    both_n = 0;
    busy_n = 0;
    reset  = 1'b1;
    rx_i   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    chk("reset data_o", data_o, 8'h00);
    chk("reset valid_o", valid_o, 1'b0);
    chk("reset frame_error_o", frame_error_o, 1'b0);
    chk("reset busy_o", busy_o, 1'b0);

    // Single byte at nominal rate: strobe timing relative to the pin edge.
    drive(1'b1, 20);
    clear_log();
    fall_cyc = cyc;
    send_byte(8'h41, 104, 1'b1);
    drive(1'b1, 200);
    chk("0x41 strobe count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("0x41 data", got_q[0], 8'h41);
      chk("0x41 latency", got_cyc[0] - fall_cyc, 2 + 52 + 9 * 104 + 1);
    end
    chk("0x41 no frame error", ferr_n, 0);
    chk("0x41 data held", data_o, 8'h41);

    // Back-to-back frames with a single stop bit each.
    clear_log();
    exp_q.delete();
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    foreach (exp_q[i]) send_byte(exp_q[i], 104, 1'b1);
    drive(1'b1, 200);
    chk("b2b strobe count", got_q.size(), exp_q.size());
    n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++) chk($sformatf("b2b data[%0d]", i), got_q[i], exp_q[i]);
    chk("b2b no frame error", ferr_n, 0);

    // Short low glitch: false start rejected after half a bit.
    clear_log();
    drive(1'b0, 30);
    drive(1'b1, 200);
    chk("glitch no valid", got_q.size(), 0);
    chk("glitch no frame error", ferr_n, 0);
    chk("glitch busy cycles", busy_n, 52);
    chk("glitch idle after", busy_o, 1'b0);

    // Stop bit low followed by a long break: exactly one error strobe.
    clear_log();
    drive(1'b0, 104);
    for (int i = 0; i < 8; i++) drive(rb_bit(8'h55, i), 104);
    drive(1'b0, 2000);
    chk("break frame errors", ferr_n, 1);
    chk("break no valid", got_q.size(), 0);
    chk("break data_o", data_o, 8'h55);
    chk("break busy held", busy_o, 1'b1);
    drive(1'b1, 50);
    chk("break release idle", busy_o, 1'b0);
    clear_log();
    send_byte(8'h33, 104, 1'b1);
    drive(1'b1, 100);
    chk("after break count", got_q.size(), 1);
    if (got_q.size() > 0) chk("after break data", got_q[0], 8'h33);

    // Reset in the middle of data bit 4 of 0xA5 (bit 4 is low).
    clear_log();
    drive(1'b0, 104);
    for (int i = 0; i < 4; i++) drive(rb_bit(8'hA5, i), 104);
    drive(1'b0, 52);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("midreset data_o", data_o, 8'h00);
    chk("midreset valid_o", valid_o, 1'b0);
    chk("midreset frame_error_o", frame_error_o, 1'b0);
    chk("midreset busy_o", busy_o, 1'b0);
    drive(1'b0, 20);
    drive(1'b1, 300);
    chk("midreset no valid", got_q.size(), 0);
    chk("midreset no frame error", ferr_n, 0);
    clear_log();
    send_byte(8'h12, 104, 1'b1);
    drive(1'b1, 100);
    chk("post reset count", got_q.size(), 1);
    if (got_q.size() > 0) chk("post reset data", got_q[0], 8'h12);

    // Baud mismatch of about +/-4%.
    clear_log();
    send_byte(8'hC3, 100, 1'b1);
    drive(1'b1, 100);
    send_byte(8'hC3, 108, 1'b1);
    drive(1'b1, 100);
    chk("tolerance count", got_q.size(), 2);
    for (int i = 0; i < got_q.size() && i < 2; i++) chk($sformatf("tolerance data[%0d]", i), got_q[i], 8'hC3);
    chk("tolerance no frame error", ferr_n, 0);

    // Random bytes, random rate within tolerance, random idle gaps.
    clear_log();
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      rb  = 8'($urandom_range(0, 255));
      cpb = int'($urandom_range(100, 108));
      gap = int'($urandom_range(0, 20));
      exp_q.push_back(rb);
      send_byte(rb, cpb, 1'b1);
      if (gap > 0) drive(1'b1, gap);
    end
    drive(1'b1, 300);
    chk("random strobe count", got_q.size(), exp_q.size());
    n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++) chk($sformatf("random data[%0d]", i), got_q[i], exp_q[i]);
    chk("random no frame error", ferr_n, 0);
    chk("valid and error never together", both_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
